// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Holds the hex glyph table, the blank pattern and the digit-count limit.
package ssd_pkg;

    // Largest display the scan controller supports; sizes the digit index.
    localparam int NDIG_MAX = 8;

    typedef logic [6:0] seg_t;

    // Segment order is a..g from bit 6 down to bit 0, active-high.
    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam seg_t GLYPH [0:15] = '{
        7'b1111110, // 0
        7'b0110000, // 1
        7'b1101101, // 2
        7'b1111001, // 3
        7'b0110011, // 4
        7'b1011011, // 5
        7'b1011111, // 6
        7'b1110000, // 7
        7'b1111111, // 8
        7'b1111011, // 9
        7'b1110111, // A
        7'b0011111, // b
        7'b1001110, // C
        7'b0111101, // d
        7'b1001111, // E
        7'b1000111  // F
    };

    function automatic seg_t hex_to_seg(input logic [3:0] h);
        return GLYPH[h];
    endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// Free-running prescaler that emits a registered one-cycle tick every
// CLK_DIV clocks. Ports: clk, reset (sync, active-high), tick (out).
module ssd_tick_gen #(
    parameter int CLK_DIV = 200000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // tick is high for the cycle right after the count reaches LAST,
    // so the first tick after reset lands exactly CLK_DIV edges later.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller with shadowed display data.
// Ports: clk, reset, load, data, dp, blank_mask, blink_mask, lz_en in;
//        an (anodes), seg (a..g), dp_out, tick (digit advance) out.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NDIG           = 4,
    parameter int CLK_DIV        = 200000,
    parameter int GUARD          = 1,
    parameter int BLINK_DIV      = 128,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [4*NDIG-1:0] data,
    input  logic [NDIG-1:0]   dp,
    input  logic [NDIG-1:0]   blank_mask,
    input  logic [NDIG-1:0]   blink_mask,
    input  logic              lz_en,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              dp_out,
    output logic              tick
);

    localparam int IW = $clog2(NDIG_MAX);
    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIG - 1);
    localparam logic [GW-1:0]   GUARD_V    = GW'(GUARD);
    localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [NDIG-1:0] AN_XOR     = {NDIG{AN_ACTIVE_LOW}};
    localparam seg_t            SEG_XOR    = {7{SEG_ACTIVE_LOW}};

    logic [IW-1:0]     idx;
    logic [GW-1:0]     guard_q;
    logic [BW-1:0]     bcnt;
    logic              blink_phase;

    logic [4*NDIG-1:0] sh_data;
    logic [NDIG-1:0]   sh_dp;
    logic [NDIG-1:0]   sh_blank;
    logic [NDIG-1:0]   sh_blink;

    logic [NDIG-1:0]   onehot;
    logic [NDIG-1:0]   sup;
    logic [3:0]        nib;
    logic              run;

    logic [GW-1:0]     guard_eff;
    logic              guard_dark;
    logic              blank_b;
    logic              blink_b;
    logic              dp_b;
    logic              sup_b;
    logic              dark;
    logic [NDIG-1:0]   an_h;
    seg_t              seg_h;
    logic              dp_h;

    ssd_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Digit select and leading-zero mask.  The suppression run starts at
    // the top digit and stops at the first nonzero nibble; digit 0 is
    // never part of it, so an all-zero value still shows a single 0.
    always_comb begin
        onehot = '0;
        nib    = '0;
        sup    = '0;
        run    = lz_en;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) begin
                onehot[i] = 1'b1;
                nib       = sh_data[4*i +: 4];
            end
        end
        for (int i = NDIG - 1; i > 0; i--) begin
            run    = run & (sh_data[4*i +: 4] == 4'h0);
            sup[i] = run;
        end
    end

    // The tick edge itself counts as the first guard cycle, so GUARD
    // dark cycles follow each advance and the new anode comes up after.
    assign guard_eff  = tick ? GUARD_V : guard_q;
    assign guard_dark = |guard_eff;

    assign blank_b = |(sh_blank & onehot);
    assign blink_b = |(sh_blink & onehot);
    assign dp_b    = |(sh_dp & onehot);
    assign sup_b   = |(sup & onehot);

    // A suppressed zero keeps its anode only to light a requested dp.
    assign dark  = guard_dark | blank_b | (blink_phase & blink_b)
                 | (sup_b & ~dp_b);
    assign an_h  = dark ? '0 : onehot;
    assign seg_h = (dark | sup_b) ? SEG_BLANK : hex_to_seg(nib);
    assign dp_h  = ~dark & dp_b;

    // Shadow capture: idx and shadow both update on the same edge, so a
    // load coinciding with an advance never shows old data on new idx.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_blink <= '0;
        end else if (load) begin
            sh_data  <= data;
            sh_dp    <= dp;
            sh_blank <= blank_mask;
            sh_blink <= blink_mask;
        end
    end

    // Scan position and blink phase, both stepped by the digit tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            if (bcnt == BLINK_LAST) begin
                bcnt        <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            guard_q <= '0;
        end else begin
            guard_q <= guard_dark ? guard_eff - GW'(1) : '0;
        end
    end

    // Pin register; polarity is folded in as the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            an     <= AN_XOR;
            seg    <= SEG_BLANK ^ SEG_XOR;
            dp_out <= SEG_ACTIVE_LOW;
        end else begin
            an     <= an_h ^ AN_XOR;
            seg    <= seg_h ^ SEG_XOR;
            dp_out <= dp_h ^ SEG_ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl: two instances (GUARD 0 and 1)
// compared every cycle against a time-based reference model.
module tb_ssd_scan_ctrl;

    localparam int NDIG = 4;
    localparam int CDIV = 4;
    localparam int BDIV = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic        lz_en = 1'b0;

    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dpo0, dpo1;
    logic        tick0, tick1;

    always #5 clk = ~clk;

    ssd_scan_ctrl #(
        .NDIG(NDIG), .CLK_DIV(CDIV), .GUARD(0), .BLINK_DIV(BDIV),
        .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) u0 (
        .clk(clk), .reset(reset), .load(load), .data(data), .dp(dp),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
        .an(an0), .seg(seg0), .dp_out(dpo0), .tick(tick0)
    );

    ssd_scan_ctrl #(
        .NDIG(NDIG), .CLK_DIV(CDIV), .GUARD(1), .BLINK_DIV(BDIV),
        .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) u1 (
        .clk(clk), .reset(reset), .load(load), .data(data), .dp(dp),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
        .an(an1), .seg(seg1), .dp_out(dpo1), .tick(tick1)
    );

    int tests = 0;
    int fails = 0;

    // Model state: edges since the last reset edge plus the shadow copy.
    int          e = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_blank = '0;
    logic [3:0]  m_blink = '0;

    logic [3:0]  x_an0, x_an1;
    logic [6:0]  x_seg0, x_seg1;
    logic        x_dp0, x_dp1, x_tk0, x_tk1;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    // Ticks completed after `edges` edges: first tick lands at edge CDIV
    // and the digit moves one edge later.
    function automatic int advances(input int edges);
        return (edges >= 1) ? (edges - 1) / CDIV : 0;
    endfunction

    function automatic int cur_idx();
        return advances(e) % NDIG;
    endfunction

    // Expected pins after the coming edge for a given guard length.
    function automatic void predict(input int g,
                                    output logic [3:0] x_an,
                                    output logic [6:0] x_seg,
                                    output logic x_dp,
                                    output logic x_tk);
        int n, a, idx, ph;
        logic [3:0] lit;
        logic [6:0] sh;
        logic       dh, sup, dark;
        if (reset) begin
            x_an = 4'hF; x_seg = 7'h7F; x_dp = 1'b1; x_tk = 1'b0;
            return;
        end
        n    = e + 1;
        x_tk = (n >= CDIV) && (n % CDIV == 0);
        a    = advances(e);
        idx  = a % NDIG;
        ph   = (a / BDIV) % 2;
        lit  = '0;
        sh   = '0;
        dh   = 1'b0;
        if (!(e >= CDIV && (e % CDIV) < g)) begin
            sup  = lz_en && idx != 0 && ((m_data >> (4 * idx)) == 16'h0);
            dark = m_blank[idx] || (ph == 1 && m_blink[idx])
                || (sup && !m_dp[idx]);
            if (!dark) begin
                lit[idx] = 1'b1;
                dh       = m_dp[idx];
                if (!sup) sh = glyph(m_data[4*idx +: 4]);
            end
        end
        x_an  = ~lit;
        x_seg = ~sh;
        x_dp  = ~dh;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h at e=%0d", tag, obs, exp, e);
        end
    endtask

    task automatic step();
        predict(0, x_an0, x_seg0, x_dp0, x_tk0);
        predict(1, x_an1, x_seg1, x_dp1, x_tk1);
        if (reset) begin
            e = 0;
            m_data = '0; m_dp = '0; m_blank = '0; m_blink = '0;
        end else begin
            e++;
            if (load) begin
                m_data = data; m_dp = dp;
                m_blank = blank_mask; m_blink = blink_mask;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("g0.an",   {4'h0, an0},   {4'h0, x_an0});
        check("g0.seg",  {1'b0, seg0},  {1'b0, x_seg0});
        check("g0.dp",   {7'h0, dpo0},  {7'h0, x_dp0});
        check("g0.tick", {7'h0, tick0}, {7'h0, x_tk0});
        check("g1.an",   {4'h0, an1},   {4'h0, x_an1});
        check("g1.seg",  {1'b0, seg1},  {1'b0, x_seg1});
        check("g1.dp",   {7'h0, dpo1},  {7'h0, x_dp1});
        check("g1.tick", {7'h0, tick1}, {7'h0, x_tk1});
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic load_step(input logic [15:0] d, input logic [3:0] p,
                             input logic [3:0] bl, input logic [3:0] bk);
        data = d; dp = p; blank_mask = bl; blink_mask = bk;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        int k;
        @(negedge clk);
        reset = 1'b1;
        run(2);
        reset = 1'b0;

        // Plain rotation of 0, A, 2, 1.
        load_step(16'h12A0, 4'h0, 4'h0, 4'h0);
        run(24);

        // Leading-zero suppression, including the all-zero value.
        lz_en = 1'b1;
        load_step(16'h0030, 4'h0, 4'h0, 4'h0);
        run(20);
        load_step(16'h0000, 4'h0, 4'h0, 4'h0);
        run(20);
        load_step(16'h0000, 4'b0100, 4'h0, 4'h0);
        run(20);
        lz_en = 1'b0;

        // Blink on digit 0, dp on digit 2, then a blanked digit.
        load_step(16'h4567, 4'b0100, 4'h0, 4'b0001);
        run(120);
        load_step(16'h89AB, 4'b1000, 4'b1000, 4'h0);
        run(20);

        // Load landing on the same edge as the digit advance.
        load_step(16'h1111, 4'h0, 4'h0, 4'h0);
        k = 0;
        while (tick0 !== 1'b1 && k < 2 * CDIV) begin
            step();
            k++;
        end
        check("tick_wait", {7'h0, tick0}, 8'h01);
        load_step(16'h2222, 4'h0, 4'h0, 4'h0);
        run(16);

        // Reset while digit 2 is selected.
        k = 0;
        while (cur_idx() != 2 && k < 4 * NDIG * CDIV) begin
            step();
            k++;
        end
        check("idx2_wait", 8'(cur_idx()), 8'h02);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(3 * CDIV);

        // Randomised loads, masks, lz_en toggles and occasional resets.
        for (int r = 0; r < 400; r++) begin
            load  = 1'b0;
            reset = 1'b0;
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < 4; j++)
                    data[4*j +: 4] = ($urandom_range(0, 1) == 1)
                                   ? 4'($urandom) : 4'h0;
                dp         = 4'($urandom);
                blank_mask = 4'($urandom & $urandom & $urandom);
                blink_mask = 4'($urandom);
                load       = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
            step();
        end
        load  = 1'b0;
        reset = 1'b0;
        run(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller. It time-multiplexes NDIG hex digits onto one shared segment bus plus per-digit anode enables. Each digit has decimal point, blanking, blink and leading-zero suppression controls. Display data is latched into a shadow register on a load strobe, so the processor-side value can change without tearing. It sits between the board debug-mux logic (register/PC/ID selection) and the FPGA display pins.

Parameters:
NDIG, 4, number of digits (legal 1..8)
CLK_DIV, 200000, clk cycles per scan tick (legal >= 2)
GUARD, 1, cycles all anodes are forced inactive after each digit switch (anti-ghosting); legal 0..CLK_DIV-1
BLINK_DIV, 128, scan ticks per blink half-period (legal >= 1)
AN_ACTIVE_LOW, 1, 1 = anode enable is driven 0
SEG_ACTIVE_LOW, 1, 1 = lit segment/dp is driven 0

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  capture data/dp/blank_mask/blink_mask into shadow this edge
data  in  4*NDIG  nibble i = digit i value
dp  in  NDIG  decimal point request per digit
blank_mask  in  NDIG  1 = digit i always dark
blink_mask  in  NDIG  1 = digit i dark during blink-off phase
lz_en  in  1  leading-zero suppression enable (live, not shadowed)
an  out  NDIG  anode enables, bit i = digit i
seg  out  7  segments, seg[6]=a ... seg[0]=g
dp_out  out  1  decimal point segment
tick  out  1  one-cycle pulse per digit advance

Behaviour:
- One clock: clk. reset is synchronous and active-high. Reset clears prescaler, digit index, guard counter, blink counter/phase and all shadow registers. It registers an = all inactive, seg = all off, dp_out = off and tick = 0. Reset has priority over load.
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick is registered high for exactly the cycle after the count equals CLK_DIV-1, giving period CLK_DIV.
- Digit index idx: advances on tick and wraps NDIG-1 -> 0. For NDIG=1 idx stays 0.
- Guard: on each tick the guard counter loads GUARD. While it is nonzero, all anodes are inactive and it decrements. GUARD=0 means no dark gap.
- Blink: a counter of ticks toggles blink_phase every BLINK_DIV ticks. blink_phase=1 is the off phase.
- Shadow: when load=1 at an edge, all shadowed inputs are captured. Pins reflect the change from the following edge (1-cycle latency).
- Digit dark condition: blank_mask[idx] or (blink_phase and blink_mask[idx]) or leading-zero suppressed.
- Leading-zero suppression (lz_en=1): scanning from digit NDIG-1 downward, every zero nibble is suppressed up to the first nonzero nibble. Digit 0 is never suppressed. A suppressed digit still shows its dp if dp is set: the anode stays active with seg off.
- Output register: an/seg/dp_out are registered from the current idx, shadow and guard state.
  - Active digit: one-hot anode at idx.
  - Dark digit: anode inactive, seg and dp off.
  - Polarities are applied last per AN_ACTIVE_LOW / SEG_ACTIVE_LOW.
- Glyphs (active-high, a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Simultaneous load and tick: the new shadow and the new idx both take effect at the next edge. No stale mix is allowed.
- Reset mid-scan: restarts at digit 0 with the full CLK_DIV period before the first tick.

Decomposition:
- Package ssd_pkg: the 16-entry active-high glyph constant table, a hex-to-segment function, SEG_BLANK constant, digit-count limit constant.
- Sub-module ssd_tick_gen (parametrised prescaler producing the tick pulse). It is reusable by other board-level timing blocks.

Test Plan:
1. Bench parameters NDIG=4, CLK_DIV=4, GUARD=0, active-low. Stimulus: reset, load data=0x12A0. -> Pins rotate an=1110,1101,1011,0111 every 4 cycles; seg=0000001,0001000,0010010,1001111 (0,A,2,1).
2. Same, lz_en=1, data=0x0030. -> Digits 3 and 2 dark (an bit high, seg=1111111); digit 1 shows 3; digit 0 shows 0. data=0x0000 -> only digit 0 lit, showing 0.
3. GUARD=1. -> In the first cycle after every tick, an=1111. The new digit's anode asserts on the next cycle. Measured dark gap is exactly 1 cycle.
4. blink_mask=0001, BLINK_DIV=2. -> Digit 0 lit for 2 ticks, then dark for 2 ticks, repeating; other digits unaffected. dp[2]=1 with blank_mask[2]=0 -> dp_out=0 only while idx=2.
5. load asserted in the same cycle as tick, data 0x1111 -> 0x2222. -> The first digit displayed after that tick shows 2; no cycle shows 1 on the new idx.
6. Assert reset while idx=2. -> The next edge gives an=1111, seg=1111111, tick=0. Digit 0 then drives; the first tick arrives exactly CLK_DIV cycles later.
